// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide memory bus shared by the fetch/LSB requesters and the arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_arbiter_if #(
  parameter int LINE_BYTES = 16
);
  logic                    rdy_in;
  logic                    clear_in;
  logic                    if_valid_in;
  logic [31:0]             if_addr_in;
  logic                    if_done_out;
  logic [LINE_BYTES*8-1:0] if_data_out;
  logic                    lsb_valid_in;
  logic                    lsb_wr_in;
  logic [31:0]             lsb_addr_in;
  logic [1:0]              lsb_size_in;
  logic [31:0]             lsb_wdata_in;
  logic                    lsb_done_out;
  logic [31:0]             lsb_rdata_out;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  modport slave (
    input  rdy_in, clear_in,
    input  if_valid_in, if_addr_in,
    output if_done_out, if_data_out,
    input  lsb_valid_in, lsb_wr_in, lsb_addr_in, lsb_size_in, lsb_wdata_in,
    output lsb_done_out, lsb_rdata_out,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, clear_in,
    output if_valid_in, if_addr_in,
    input  if_done_out, if_data_out,
    output lsb_valid_in, lsb_wr_in, lsb_addr_in, lsb_size_in, lsb_wdata_in,
    input  lsb_done_out, lsb_rdata_out,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between icache line fills and LSB loads/stores,
// serialising each access into little-endian byte beats with registered memory outputs.
module mem_arbiter #(
  parameter int LINE_BYTES = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  mem_arbiter_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [31:0]             mem_a_q, mem_a_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    if_done_q, if_done_d;
  logic                    lsb_done_q, lsb_done_d;
  logic [LINE_BYTES*8-1:0] if_data_q, if_data_d;
  logic [31:0]             lsb_rdata_q, lsb_rdata_d;

  logic                    io_store;
  logic                    store_blocked;
  logic [CNT_W-1:0]        lsb_len;

  // IO stores are forced to a single byte so the UART sees exactly one write.
  assign io_store      = bus.lsb_wr_in && (bus.lsb_addr_in[17:16] == 2'b11);
  assign store_blocked = io_store && bus.io_buffer_full;
  assign lsb_len       = io_store                  ? CNT_W'(1) :
                         (bus.lsb_size_in == 2'd0) ? CNT_W'(1) :
                         (bus.lsb_size_in == 2'd1) ? CNT_W'(2) : CNT_W'(4);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        cnt_d    = '0;
        if (bus.rdy_in) begin
          if (bus.lsb_valid_in && bus.lsb_wr_in && !store_blocked) begin
            state_d    = STORE;
            mem_a_d    = bus.lsb_addr_in;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.lsb_wdata_in[7:0];
            wdata_d    = bus.lsb_wdata_in >> 8;
            len_d      = lsb_len;
          end else if (bus.lsb_valid_in && !bus.lsb_wr_in && !bus.clear_in) begin
            state_d     = LOAD;
            mem_a_d     = bus.lsb_addr_in;
            lsb_rdata_d = '0;
            len_d       = lsb_len;
          end else if (bus.if_valid_in && !bus.clear_in) begin
            state_d = IFETCH;
            mem_a_d = bus.if_addr_in & ~32'(LINE_BYTES - 1);
            len_d   = CNT_W'(LINE_BYTES);
          end
        end
      end

      IFETCH, LOAD: begin
        if (bus.clear_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Read data trails the address by one cycle, so lane k lands while cnt = k+1.
          if (state_q == IFETCH) begin
            for (int i = 0; i < LINE_BYTES; i++)
              if (cnt_q == CNT_W'(i + 1)) if_data_d[8*i +: 8] = bus.mem_din;
          end else begin
            for (int i = 0; i < 4; i++)
              if (cnt_q == CNT_W'(i + 1)) lsb_rdata_d[8*i +: 8] = bus.mem_din;
          end
          if (cnt_q == len_q) begin
            state_d    = DONE;
            if_done_d  = (state_q == IFETCH);
            lsb_done_d = (state_q == LOAD);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) < len_q) mem_a_d = mem_a_q + 32'd1;
          end
        end
      end

      STORE: begin
        if (cnt_q == len_q - CNT_W'(1)) begin
          state_d    = DONE;
          mem_wr_d   = 1'b0;
          lsb_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          mem_a_d    = mem_a_q + 32'd1;
          mem_dout_d = wdata_q[7:0];
          wdata_d    = wdata_q >> 8;
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      wdata_q     <= '0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      wdata_q     <= wdata_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign bus.mem_a         = mem_a_q;
  assign bus.mem_dout      = mem_dout_q;
  assign bus.mem_wr        = mem_wr_q;
  assign bus.if_done_out   = if_done_q;
  assign bus.if_data_out   = if_data_q;
  assign bus.lsb_done_out  = lsb_done_q;
  assign bus.lsb_rdata_out = lsb_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 1-cycle-latency byte RAM model plus cycle-exact checks
// of beat addresses, write data, done timing, priority, IO back-pressure, clear and reset.
module tb_mem_arbiter;
  localparam int LB = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic ram_init = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] ram [0:65535];

  mem_arbiter_if #(.LINE_BYTES(LB)) bus ();

  mem_arbiter #(.LINE_BYTES(LB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 8'h11 * 8'(a[1:0] + 2'd1);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Byte-wide RAM: address sampled at the edge, data on mem_din the following cycle.
  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(32'(i));
    end else begin
      if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[15:0]];
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
    bus.lsb_valid_in = 1'b1;
    bus.lsb_wr_in    = wr;
    bus.lsb_addr_in  = addr;
    bus.lsb_size_in  = size;
    bus.lsb_wdata_in = wdata;
  endtask

  // Full load with cycle-exact beat and done checks; caller is in an IDLE cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input int n, input logic [31:0] exp_data);
    lsb_req(1'b0, addr, size, 32'h0);
    tick();
    for (int k = 0; k <= n; k++) begin
      if (k < n) chk({tag, "_addr"}, 128'(bus.mem_a), 128'(addr + 32'(k)));
      chk({tag, "_nodone"}, 128'(bus.lsb_done_out), 128'(0));
      tick();
    end
    chk({tag, "_done"}, 128'(bus.lsb_done_out), 128'(1));
    chk({tag, "_data"}, 128'(bus.lsb_rdata_out), 128'(exp_data));
    bus.lsb_valid_in = 1'b0;
    tick();
    chk({tag, "_pulse"}, 128'(bus.lsb_done_out), 128'(0));
  endtask

  logic [127:0] line_exp;

  initial begin
    bus.rdy_in = 1'b0;         bus.clear_in = 1'b0;
    bus.if_valid_in = 1'b0;    bus.if_addr_in = '0;
    bus.lsb_valid_in = 1'b0;   bus.lsb_wr_in = 1'b0;
    bus.lsb_addr_in = '0;      bus.lsb_size_in = '0;
    bus.lsb_wdata_in = '0;     bus.io_buffer_full = 1'b0;

    tick();
    ram_init = 1'b0;
    tick();
    chk("rst_mem_a", 128'(bus.mem_a), 128'(0));
    chk("rst_mem_wr", 128'(bus.mem_wr), 128'(0));
    chk("rst_mem_dout", 128'(bus.mem_dout), 128'(0));
    chk("rst_if_done", 128'(bus.if_done_out), 128'(0));
    chk("rst_lsb_done", 128'(bus.lsb_done_out), 128'(0));
    chk("rst_if_data", bus.if_data_out, 128'(0));
    chk("rst_lsb_rdata", 128'(bus.lsb_rdata_out), 128'(0));
    rst_in = 1'b1;
    bus.rdy_in = 1'b1;
    tick();

    // 4-byte load
    do_load("ld4", 32'h100, 2'd2, 4, 32'h44332211);

    // 2-byte store then readback
    lsb_req(1'b1, 32'h202, 2'd1, 32'h0000BEEF);
    tick();
    chk("st2_wr0", 128'(bus.mem_wr), 128'(1));
    chk("st2_a0", 128'(bus.mem_a), 128'(32'h202));
    chk("st2_d0", 128'(bus.mem_dout), 128'(8'hEF));
    tick();
    chk("st2_wr1", 128'(bus.mem_wr), 128'(1));
    chk("st2_a1", 128'(bus.mem_a), 128'(32'h203));
    chk("st2_d1", 128'(bus.mem_dout), 128'(8'hBE));
    chk("st2_nodone", 128'(bus.lsb_done_out), 128'(0));
    tick();
    chk("st2_done", 128'(bus.lsb_done_out), 128'(1));
    chk("st2_wr_off", 128'(bus.mem_wr), 128'(0));
    bus.lsb_valid_in = 1'b0;
    tick();
    do_load("st2_rb", 32'h202, 2'd1, 2, 32'h0000BEEF);

    // Line fill at 0x1004 with an LSB load raised in fill cycle 3
    bus.if_valid_in = 1'b1;
    bus.if_addr_in  = 32'h1004;
    tick();
    for (int k = 0; k < LB; k++) begin
      chk("fill_addr", 128'(bus.mem_a), 128'(32'h1000 + 32'(k)));
      chk("fill_nodone", 128'(bus.if_done_out), 128'(0));
      if (k == 3) lsb_req(1'b0, 32'h400, 2'd0, 32'h0);
      tick();
    end
    chk("fill_nodone16", 128'(bus.if_done_out), 128'(0));
    tick();
    for (int i = 0; i < LB; i++) line_exp[8*i +: 8] = init_byte(32'h1000 + 32'(i));
    chk("fill_done", 128'(bus.if_done_out), 128'(1));
    chk("fill_data", bus.if_data_out, line_exp);
    bus.if_valid_in = 1'b0;
    tick();
    chk("fill_idle_hold", 128'(bus.mem_a), 128'(32'h100F));
    chk("fill_pulse", 128'(bus.if_done_out), 128'(0));
    tick();
    chk("wait_ld_a0", 128'(bus.mem_a), 128'(32'h400));
    tick();
    tick();
    chk("wait_ld_done", 128'(bus.lsb_done_out), 128'(1));
    chk("wait_ld_data", 128'(bus.lsb_rdata_out), 128'(32'h5A));
    bus.lsb_valid_in = 1'b0;
    tick();

    // Simultaneous requests: LSB first, fill after the LSB DONE cycle
    bus.if_valid_in = 1'b1;
    bus.if_addr_in  = 32'h2000;
    lsb_req(1'b0, 32'h101, 2'd0, 32'h0);
    tick();
    chk("prio_lsb_a", 128'(bus.mem_a), 128'(32'h101));
    tick();
    tick();
    chk("prio_lsb_done", 128'(bus.lsb_done_out), 128'(1));
    chk("prio_lsb_data", 128'(bus.lsb_rdata_out), 128'(32'h22));
    bus.lsb_valid_in = 1'b0;
    tick();
    chk("prio_gap", 128'(bus.mem_a), 128'(32'h101));
    tick();
    chk("prio_if_a", 128'(bus.mem_a), 128'(32'h2000));
    for (int k = 0; k < LB + 1; k++) tick();
    chk("prio_if_done", 128'(bus.if_done_out), 128'(1));
    bus.if_valid_in = 1'b0;
    tick();

    // IO store held off by a full UART buffer; size forced to 1 byte
    bus.io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h30000, 2'd2, 32'h123456A5);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("io_wait_wr", 128'(bus.mem_wr), 128'(0));
      chk("io_wait_done", 128'(bus.lsb_done_out), 128'(0));
    end
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_wr", 128'(bus.mem_wr), 128'(1));
    chk("io_a", 128'(bus.mem_a), 128'(32'h30000));
    chk("io_d", 128'(bus.mem_dout), 128'(8'hA5));
    tick();
    chk("io_done", 128'(bus.lsb_done_out), 128'(1));
    chk("io_wr_off", 128'(bus.mem_wr), 128'(0));
    bus.lsb_valid_in = 1'b0;
    tick();
    chk("io_pulse", 128'(bus.lsb_done_out), 128'(0));

    // clear aborts a load in beat 2
    lsb_req(1'b0, 32'h100, 2'd2, 32'h0);
    tick();
    tick();
    tick();
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    bus.lsb_valid_in = 1'b0;
    chk("clr_ld_a", 128'(bus.mem_a), 128'(32'h102));
    for (int k = 0; k < 4; k++) begin
      chk("clr_ld_nodone", 128'(bus.lsb_done_out), 128'(0));
      tick();
    end

    // clear during a store is ignored
    lsb_req(1'b1, 32'h500, 2'd2, 32'hCAFEF00D);
    tick();
    chk("clr_st_d0", 128'(bus.mem_dout), 128'(8'h0D));
    tick();
    tick();
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    chk("clr_st_wr3", 128'(bus.mem_wr), 128'(1));
    chk("clr_st_a3", 128'(bus.mem_a), 128'(32'h503));
    chk("clr_st_d3", 128'(bus.mem_dout), 128'(8'hCA));
    tick();
    chk("clr_st_done", 128'(bus.lsb_done_out), 128'(1));
    bus.lsb_valid_in = 1'b0;
    tick();
    do_load("clr_st_rb", 32'h500, 2'd2, 4, 32'hCAFEF00D);

    // clear in IDLE blocks a load for that edge only
    lsb_req(1'b0, 32'h100, 2'd0, 32'h0);
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    chk("clr_idle_hold", 128'(bus.mem_a), 128'(32'h503));
    tick();
    chk("clr_idle_acc", 128'(bus.mem_a), 128'(32'h100));
    tick();
    tick();
    chk("clr_idle_data", 128'(bus.lsb_rdata_out), 128'(32'h11));
    bus.lsb_valid_in = 1'b0;
    tick();

    // asynchronous reset mid-fill
    bus.if_valid_in = 1'b1;
    bus.if_addr_in  = 32'h1000;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_fill_a", 128'(bus.mem_a), 128'(32'h1005));
    rst_in = 1'b0;
    #1;
    chk("arst_mem_a", 128'(bus.mem_a), 128'(0));
    chk("arst_if_data", bus.if_data_out, 128'(0));
    chk("arst_lsb_rdata", 128'(bus.lsb_rdata_out), 128'(0));
    chk("arst_mem_dout", 128'(bus.mem_dout), 128'(0));
    chk("arst_mem_wr", 128'(bus.mem_wr), 128'(0));
    bus.if_valid_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port of the RISC-V core and shares it between two requesters: instruction fetch (cache-line fills) and the load/store buffer (1/2/4-byte loads and stores).
- Sits between the icache/LSB and the top-level RAM/UART interface.
- Serialises multi-byte accesses into little-endian byte beats, honours the IO write back-pressure signal, and aborts speculative reads on pipeline clear.

Parameters:
- LINE_BYTES, 16, icache line size in bytes; power of two, at least 4.

Ports:
- clk_in  in  1  system clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; when low, no new request is accepted
- clear_in  in  1  pipeline flush (branch mispredict)
- if_valid_in  in  1  line-fill request; held until if_done_out
- if_addr_in  in  32  line address; low log2(LINE_BYTES) bits ignored
- if_done_out  out  1  one-cycle pulse, line data valid
- if_data_out  out  LINE_BYTES*8  line, byte 0 in bits [7:0]
- lsb_valid_in  in  1  LSB request; held until lsb_done_out
- lsb_wr_in  in  1  1 = store, 0 = load
- lsb_addr_in  in  32  byte address
- lsb_size_in  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal
- lsb_wdata_in  in  32  store data, little-endian
- lsb_done_out  out  1  one-cycle pulse, access complete
- lsb_rdata_out  out  32  load data, zero-extended (the LSB sign-extends)
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART write buffer full

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; mem_a = 0, mem_dout = 0, mem_wr = 0; both done outputs = 0; if_data_out = 0; lsb_rdata_out = 0; byte counter = 0.
- States:
  - IDLE.
  - IFETCH: N = LINE_BYTES.
  - LOAD: N = 1, 2 or 4.
  - STORE: N = 1, 2 or 4.
  - DONE: one cycle; the done output is high and no request is sampled.
- Acceptance in IDLE at a rising edge requires rdy_in = 1.
- Priority: LSB over IF. A fill in progress is never preempted; a waiting LSB request is served in the next IDLE after the fill completes.
- All memory outputs are registered.
- At the acceptance edge: mem_a <= base address; for a store, mem_wr <= 1 and mem_dout <= byte 0. Beat k drives mem_a = base + k during cycle k, for k = 0..N-1.
- Reads:
  - RAM latency is 1 cycle; the byte for beat k appears on mem_din in cycle k+1.
  - The controller captures byte k into lane k at the end of cycle k+1.
  - The done pulse is high in cycle N+1 after acceptance, with data stable that cycle.
  - mem_wr = 0 throughout.
- Writes:
  - mem_wr = 1 for cycles 0..N-1, with mem_dout = lsb_wdata_in[8k+7:8k].
  - lsb_done_out is high in cycle N.
  - mem_wr returns to 0 in the DONE cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32. Line-fill base is if_addr_in with the low bits cleared.
- IO region: a store with lsb_addr_in[17:16] = 2'b11 is 1 byte only.
  - Accepted only while io_buffer_full = 0; otherwise the controller stays IDLE with mem_wr = 0.
  - An IF request may be accepted instead while the store waits.
  - IO loads proceed as normal loads.
- Requesters drop valid in the cycle after done. DONE returns to IDLE unconditionally, so there is a minimum 1-cycle gap between accesses.
- clear_in = 1 at an edge:
  - IFETCH or LOAD abort to IDLE with no done pulse; mem_wr stays 0; partial data is discarded.
  - STORE is unaffected, since it is committed.
  - In IDLE, IF and LOAD requests are not accepted that edge; a store may be accepted.
- rdy_in = 0 blocks acceptance only; a transfer in progress completes.
- lsb_size_in = 3: treated as 4 bytes; the verification environment flags it as an error.

Test Plan:
1. Reset, then LSB 4-byte load at 0x100, RAM[0x100..0x103] = 11 22 33 44 → mem_a 0x100..0x103 in cycles 0..3; lsb_done_out high in cycle 5 only; lsb_rdata_out = 0x44332211; mem_wr never 1.
2. 2-byte store of 0xBEEF to 0x202 → mem_wr = 1 for 2 cycles with (0x202, EF) then (0x203, BE); done in cycle 2; RAM readback matches.
3. IF fill at 0x1004 (LINE_BYTES = 16) with an LSB load raised in fill cycle 3 → mem_a 0x1000..0x100F uninterrupted; if_done_out in cycle 17; LSB load accepted at the first IDLE edge after DONE.
4. Simultaneous IF and LSB valid in IDLE → LSB served first; IF accepted after the LSB DONE cycle.
5. 1-byte store to 0x30000 with io_buffer_full = 1 for 5 cycles → mem_wr stays 0; store issues the cycle after io_buffer_full falls; single done pulse.
6. clear_in pulsed in beat 2 of a 4-byte load → no lsb_done_out, IDLE next cycle. Repeat during a 4-byte store → store completes with all 4 bytes written and done asserted. Assert rst_in low mid-fill → all outputs 0 immediately.
